// File: rtl/master_out_port.sv
// -----------------------------------------------------------------------------
// master_out_port
//
// Serial transmit master. A transfer is launched by `start` while idle. The
// block then requests the receiver with `master_valid` until the receiver
// answers with `slave_ready`. After that it shifts the captured address out
// LSB first on `tx_address`, one bit per clock. On writes it also shifts the
// captured data out LSB first on `tx_data`, alongside address bits
// 0..DATA_WIDTH-1. A single `tx_done` pulse closes the transfer.
//
// Moore FSM: IDLE -> REQ -> SEND (ADDR_WIDTH cycles) -> DONE -> IDLE.
// Every output is a register. Its value is decoded from the next state and
// next counter, so each output changes on the same edge as the state.
//
// Ports
//   clk           in   single clock; all state changes on its rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   launch request, sampled only in IDLE
//   wr            in   1 = write (data serialized), 0 = read (tx_data held 0)
//   addr_in       in   [ADDR_WIDTH-1:0] address, captured when start is accepted
//   data_in       in   [DATA_WIDTH-1:0] data, captured when start is accepted
//   slave_ready   in   receiver ready; handshake = master_valid & slave_ready
//   master_valid  out  request to the receiver, high only in REQ
//   tx_address    out  serial address line, LSB first
//   tx_data       out  serial data line, LSB first
//   busy          out  high in every state except IDLE
//   tx_done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module master_out_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8     // must not exceed ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  slave_ready,
    output logic                  master_valid,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [ADDR_WIDTH-1:0] addr_shadow;
    logic [ADDR_WIDTH-1:0] addr_shadow_next;
    // The data shadow is stored zero-extended to the address width. Address
    // bits above DATA_WIDTH then read as 0 on tx_data without a separate
    // range compare.
    logic [ADDR_WIDTH-1:0] data_shadow;
    logic [ADDR_WIDTH-1:0] data_shadow_next;
    logic                  wr_shadow;
    logic                  wr_shadow_next;

    logic                  master_valid_next;
    logic                  tx_address_next;
    logic                  tx_data_next;
    logic                  busy_next;
    logic                  tx_done_next;

    // -------------------------------------------------------------------------
    // Next-state, counter and shadow-capture logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_next       = state;
        cnt_next         = cnt;
        addr_shadow_next = addr_shadow;
        data_shadow_next = data_shadow;
        wr_shadow_next   = wr_shadow;

        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_shadow_next = addr_in;
                    data_shadow_next = ADDR_WIDTH'(data_in);
                    wr_shadow_next   = wr;
                    state_next       = REQ;
                end
            end
            REQ: begin
                // Wait for the receiver with no timeout.
                if (slave_ready) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state. The result is registered below, so
    // the outputs are Moore outputs that are glitch-free at the pins.
    // -------------------------------------------------------------------------
    always_comb begin
        master_valid_next = (state_next == REQ);
        busy_next         = (state_next != IDLE);
        tx_done_next      = (state_next == DONE);
        tx_address_next   = 1'b0;
        tx_data_next      = 1'b0;
        if (state_next == SEND) begin
            tx_address_next = addr_shadow_next[cnt_next];
            tx_data_next    = wr_shadow_next & data_shadow_next[cnt_next];
        end
    end

    // -------------------------------------------------------------------------
    // State, counter, shadow and output registers
    // -------------------------------------------------------------------------
    // NOTE: the shadow registers are cleared by reset like the control state.
    // A transfer aborted by reset then leaves no stale address or data behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_shadow  <= '0;
            data_shadow  <= '0;
            wr_shadow    <= 1'b0;
            master_valid <= 1'b0;
            tx_address   <= 1'b0;
            tx_data      <= 1'b0;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments. Every register samples the
            // pre-edge values, so ordering inside this block does not matter.
            state        <= state_next;
            cnt          <= cnt_next;
            addr_shadow  <= addr_shadow_next;
            data_shadow  <= data_shadow_next;
            wr_shadow    <= wr_shadow_next;
            master_valid <= master_valid_next;
            tx_address   <= tx_address_next;
            tx_data      <= tx_data_next;
            busy         <= busy_next;
            tx_done      <= tx_done_next;
        end
    end

endmodule

// File: tb/tb_master_out_port.sv
// -----------------------------------------------------------------------------
// tb_master_out_port
//
// Directed bench for master_out_port with ADDR_WIDTH=12 and DATA_WIDTH=8.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// A small receiver model in the bench reassembles the serial lines so each
// transfer can be compared against the values that were sent.
// -----------------------------------------------------------------------------
module tb_master_out_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          wr;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          slave_ready;
    logic          master_valid;
    logic          tx_address;
    logic          tx_data;
    logic          busy;
    logic          tx_done;

    int n_checks = 0;
    int n_errors = 0;

    master_out_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wr           (wr),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .slave_ready  (slave_ready),
        .master_valid (master_valid),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " master_valid"}, master_valid, 0);
        check({tag, " tx_address"},   tx_address,   0);
        check({tag, " tx_data"},      tx_data,      0);
        check({tag, " busy"},         busy,         0);
        check({tag, " tx_done"},      tx_done,      0);
    endtask

    // One complete transfer. `delay` is the number of REQ cycles that
    // slave_ready is held low. `inject` pulses start with addr_in=FFF
    // during SEND.
    task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                        input int delay, input bit inject);
        logic [AW-1:0] rx_addr;
        logic [DW-1:0] rx_data;
        rx_addr = '0;
        rx_data = '0;
        addr_in = a;
        data_in = d;
        wr = w;
        start = 1'b1;
        slave_ready = (delay == 0);
        tick();
        start = 1'b0;
        // Scramble the inputs after acceptance; the transfer must not change.
        addr_in = ~a;
        data_in = ~d;
        wr = ~w;
        check("req busy", busy, 1);
        check("req tx_address", tx_address, 0);
        for (int i = 0; i < delay; i++) begin
            check("req valid waiting", master_valid, 1);
            tick();
        end
        slave_ready = 1'b1;
        check("req valid", master_valid, 1);
        tick();
        for (int k = 0; k < AW; k++) begin
            check("send valid low", master_valid, 0);
            check("send done low", tx_done, 0);
            check("send busy", busy, 1);
            check("tx_address bit", tx_address, a[k]);
            check("tx_data bit", tx_data, (w && k < DW) ? d[k % DW] : 1'b0);
            rx_addr[k] = tx_address;
            if (k < DW) rx_data[k % DW] = tx_data;
            slave_ready = 1'($urandom_range(0, 1));
            if (inject && k == 3) begin
                start = 1'b1;
                addr_in = '1;
            end
            if (inject && k == 4) start = 1'b0;
            tick();
        end
        check("done pulse", tx_done, 1);
        check("done tx_address", tx_address, 0);
        check("done tx_data", tx_data, 0);
        check("done busy", busy, 1);
        check("done valid", master_valid, 0);
        tick();
        check("idle tx_done", tx_done, 0);
        check("idle busy", busy, 0);
        check("loopback addr", rx_addr, a);
        check("loopback data", rx_data, w ? d : '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        wr = 1'b0;
        addr_in = '0;
        data_in = '0;
        slave_ready = 1'b0;
        #12;
        check_quiet("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_quiet("idle no start");

        // Write A5C/3E with ready already high.
        xfer(12'hA5C, 8'h3E, 1'b1, 0, 1'b0);
        // Read: tx_data must stay 0 even with nonzero data_in.
        xfer(12'h001, 8'hFF, 1'b0, 0, 1'b0);
        // Receiver not ready for 5 cycles.
        xfer(12'h5A3, 8'hC4, 1'b1, 5, 1'b0);
        // Start pulsed during SEND must be ignored.
        xfer(12'h123, 8'h55, 1'b1, 0, 1'b1);
        tick();
        tick();
        check_quiet("no second transfer");

        // Reset at SEND bit 5 aborts without tx_done.
        addr_in = 12'hABC;
        data_in = 8'hFF;
        wr = 1'b1;
        slave_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("pre-abort bit5", tx_address, 1);
        check("pre-abort busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("async reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-abort tx_done", tx_done, 0);
            check("post-abort busy", busy, 0);
        end
        xfer(12'h800, 8'h81, 1'b1, 2, 1'b0);

        // Back-to-back: start held high gives exactly one IDLE cycle.
        addr_in = 12'h3C5;
        data_in = 8'h9A;
        wr = 1'b1;
        slave_ready = 1'b1;
        start = 1'b1;
        tick();
        check("b2b first valid", master_valid, 1);
        for (int i = 0; i < 40 && tx_done !== 1'b1; i++) tick();
        check("b2b done seen", tx_done, 1);
        tick();
        check("b2b idle busy", busy, 0);
        check("b2b idle valid", master_valid, 0);
        tick();
        check("b2b second valid", master_valid, 1);
        start = 1'b0;
        for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
        check("b2b finishes", busy, 0);

        // Loopback with random write transfers.
        for (int n = 0; n < 20; n++) begin
            xfer(AW'($urandom), DW'($urandom), 1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/master_out_port.md
MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, serial address length in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, serial data length in bits; DATA_WIDTH SHALL be <= ADDR_WIDTH.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to launch one transfer; sampled only in IDLE.
REQ-006 The block SHALL have port wr  input  1  1 = write (data serialized), 0 = read (tx_data held 0).
REQ-007 The block SHALL have port addr_in  input  ADDR_WIDTH  address to transmit, captured on start acceptance.
REQ-008 The block SHALL have port data_in  input  DATA_WIDTH  data to transmit, captured on start acceptance.
REQ-009 The block SHALL have port slave_ready  input  1  receiver ready; handshake = master_valid & slave_ready at a rising edge.
REQ-010 The block SHALL have port master_valid  output  1  registered request to the receiver.
REQ-011 The block SHALL have port tx_address  output  1  serial address line, LSB first.
REQ-012 The block SHALL have port tx_data  output  1  serial data line, LSB first, concurrent with address bits 0..DATA_WIDTH-1.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port tx_done  output  1  one-cycle completion pulse.

Function
REQ-015 The block SHALL implement a Moore FSM with states IDLE, REQ, SEND, DONE; all outputs registered.
REQ-016 IDLE: start=1 at an edge SHALL latch addr_in, data_in, wr into internal shadow registers and move to REQ; start=0 stays IDLE.
REQ-017 REQ: master_valid SHALL be 1; on the first edge with slave_ready=1 the FSM SHALL move to SEND with bit counter = 0; otherwise stay REQ indefinitely (no timeout).
REQ-018 master_valid SHALL be 1 only in REQ and deassert in the cycle immediately after the handshake edge.
REQ-019 SEND: during the cycle with counter k, tx_address SHALL equal addr_shadow[k], and tx_data SHALL equal data_shadow[k] when wr=1 and k < DATA_WIDTH, else 0.
REQ-020 Bit 0 SHALL be on the lines in the first cycle after the handshake edge; each following edge advances k by 1 (one bit per clock).
REQ-021 At the edge where k = ADDR_WIDTH-1 the FSM SHALL move to DONE; total SEND length SHALL be exactly ADDR_WIDTH cycles.
REQ-022 DONE: tx_done SHALL be 1 for exactly one cycle; tx_address and tx_data SHALL be 0; next edge SHALL return to IDLE.
REQ-023 Outside SEND, tx_address and tx_data SHALL be 0.
REQ-024 start asserted while busy=1 SHALL be ignored; shadow registers SHALL not change until the next IDLE acceptance.
REQ-025 Changes on addr_in/data_in/wr after acceptance SHALL not affect the transfer in progress.
REQ-026 slave_ready changes during SEND or DONE SHALL be ignored.
REQ-027 Back-to-back: start held high SHALL launch a new transfer from IDLE, giving minimum spacing of one IDLE cycle between tx_done and the next master_valid.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, counter 0, shadow registers 0, and master_valid, tx_address, tx_data, busy, tx_done all 0.
REQ-029 reset asserted mid-transfer SHALL abort it with no tx_done pulse; after deassertion the block SHALL wait in IDLE for a new start.

Verification
REQ-030 Write: start with addr_in=12'hA5C, data_in=8'h3E, wr=1, slave_ready=1 -> master_valid high one cycle, tx_address = 0,0,1,1,1,0,1,0,0,1,0,1 and tx_data = 0,1,1,1,1,1,0,0,0,0,0,0 over 12 cycles, then tx_done one cycle.
REQ-031 Read: addr_in=12'h001, wr=0 -> tx_address = 1 then eleven 0s, tx_data 0 throughout, tx_done after 12 SEND cycles.
REQ-032 Delayed ready: slave_ready low 5 cycles after master_valid rises -> master_valid stays high 6 cycles, bit 0 in cycle after slave_ready sampled high.
REQ-033 Ignored start: pulse start with addr_in=12'hFFF during SEND of 12'h123 -> serialized address remains 12'h123; no second transfer.
REQ-034 Reset at SEND bit 5 -> all outputs 0 asynchronously, no tx_done; subsequent start with 12'h800 transmits correctly.
REQ-035 Loopback with master_in_port: 20 random addr/data write transfers -> receiver address/data equal sent values on each transfer.
